// File: rtl/conversie_bcd.sv
// conversie_bcd: signed binary result to packed BCD for the 7-segment driver.
// The magnitude is converted by sequential double-dabble (add-3, then shift),
// one bit per cycle. A sign flag, a leading-zero blank mask and the error
// flag accompany the one-cycle valid_out pulse.
module conversie_bcd #(
  parameter int unsigned W      = 28,
  parameter int unsigned DIGITS = 9
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [W-1:0]          d_in,
  input  logic                  valid_in,
  input  logic                  err_in,
  output logic                  busy,
  output logic                  valid_out,
  output logic                  sign_out,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [DIGITS-1:0]     blank_out,
  output logic                  err_out
);

  localparam int unsigned BW = 4 * DIGITS;
  localparam int unsigned CW = $clog2(W + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [W-1:0]    mag;
  logic [BW-1:0]   bcd;
  logic            sign_r;
  logic            err_r;

  logic [BW-1:0]      bcd_adj;
  logic [DIGITS-1:0]  blank_c;
  logic               zero_above;

  // Double-dabble correction: every digit of 5 or more gets +3 before the shift
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (bcd[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end
    end
  end

  // Leading-zero mask: digit i blanks when it and every digit above it are zero
  always_comb begin
    blank_c    = '0;
    zero_above = 1'b1;
    for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
      zero_above = zero_above & (bcd[4*i +: 4] == 4'd0);
      blank_c[i] = zero_above;
    end
  end

  // Conversion FSM with registered outputs. In DONE, cnt holds the number
  // of extra wait cycles (non-zero only on the error path) before outputs load.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      mag       <= '0;
      bcd       <= '0;
      sign_r    <= 1'b0;
      err_r     <= 1'b0;
      busy      <= 1'b0;
      valid_out <= 1'b0;
      sign_out  <= 1'b0;
      bcd_out   <= '0;
      blank_out <= '0;
      err_out   <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      case (state)
        IDLE: begin
          if (valid_in) begin
            busy <= 1'b1;
            bcd  <= '0;
            if (err_in) begin
              err_r  <= 1'b1;
              sign_r <= 1'b0;
              mag    <= '0;
              cnt    <= CW'(1);
              state  <= DONE;
            end else begin
              err_r  <= 1'b0;
              sign_r <= d_in[W-1];
              mag    <= d_in[W-1] ? (~d_in + W'(1)) : d_in;
              cnt    <= CW'(W);
              state  <= CONV;
            end
          end
        end

        CONV: begin
          bcd <= {bcd_adj[BW-2:0], mag[W-1]};
          mag <= {mag[W-2:0], 1'b0};
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state <= DONE;
          end
        end

        DONE: begin
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else begin
            bcd_out   <= bcd;
            sign_out  <= sign_r & (bcd != '0);
            err_out   <= err_r;
            blank_out <= blank_c;
            valid_out <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conversie_bcd.sv
// Self-checking bench for conversie_bcd: directed corner cases plus random
// values compared against a decimal-arithmetic reference model.
module tb_conversie_bcd;

  localparam int unsigned W      = 28;
  localparam int unsigned DIGITS = 9;

  logic                 clk;
  logic                 rst;
  logic [W-1:0]         d_in;
  logic                 valid_in;
  logic                 err_in;
  logic                 busy;
  logic                 valid_out;
  logic                 sign_out;
  logic [4*DIGITS-1:0]  bcd_out;
  logic [DIGITS-1:0]    blank_out;
  logic                 err_out;

  int n_checks = 0;
  int n_pass   = 0;

  conversie_bcd #(.W(W), .DIGITS(DIGITS)) dut (
    .clk       (clk),
    .rst       (rst),
    .d_in      (d_in),
    .valid_in  (valid_in),
    .err_in    (err_in),
    .busy      (busy),
    .valid_out (valid_out),
    .sign_out  (sign_out),
    .bcd_out   (bcd_out),
    .blank_out (blank_out),
    .err_out   (err_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  // Reference: signed value -> decimal digits, sign and blank mask
  task automatic model(input logic [W-1:0] d, input logic e,
                       output logic [4*DIGITS-1:0] bcd, output logic s,
                       output logic [DIGITS-1:0] blank, output logic eo);
    longint v, m, p;
    bcd   = '0;
    blank = '0;
    s     = 1'b0;
    eo    = e;
    if (e) begin
      blank = 9'b111111110;
    end else begin
      v = longint'({36'd0, d});
      if (d[W-1]) v = v - (longint'(1) << W);
      m = (v < 0) ? -v : v;
      s = (m != 0);
      s = s & (v < 0);
      p = m;
      for (int i = 0; i < int'(DIGITS); i++) begin
        bcd[4*i +: 4] = 4'(p % 10);
        p = p / 10;
      end
      p = 1;
      for (int i = 1; i < int'(DIGITS); i++) begin
        p = p * 10;
        blank[i] = (m < p);
      end
    end
  endtask

  // One conversion: pulse valid_in, optionally inject ignored pulses after
  // cycles ia/ib, then check latency, outputs, pulse width and hold.
  task automatic run_conv(input string tag, input logic [W-1:0] d, input logic e,
                          input int ia, input int ib);
    logic [4*DIGITS-1:0] eb;
    logic [DIGITS-1:0]   ebl;
    logic                es, ee;
    int lat;
    model(d, e, eb, es, ebl, ee);
    @(negedge clk);
    d_in = d; err_in = e; valid_in = 1'b1;
    @(posedge clk); #1;
    valid_in = 1'b0; err_in = 1'b0;
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (valid_out) begin
        lat = n;
        break;
      end
      if (n == ia || n == ib) begin
        valid_in = 1'b1; d_in = 28'd1;
      end else begin
        valid_in = 1'b0;
      end
    end
    valid_in = 1'b0;
    check({tag, ".latency"}, 64'(lat), e ? 64'd2 : 64'd29);
    check({tag, ".bcd"},   64'(bcd_out),   64'(eb));
    check({tag, ".sign"},  64'(sign_out),  64'(es));
    check({tag, ".blank"}, 64'(blank_out), 64'(ebl));
    check({tag, ".err"},   64'(err_out),   64'(ee));
    @(posedge clk); #1;
    check({tag, ".pulse"}, 64'(valid_out), 64'd0);
    check({tag, ".busy"},  64'(busy),      64'd0);
    repeat (3) @(posedge clk);
    #1;
    check({tag, ".hold"},  64'(bcd_out),   64'(eb));
  endtask

  initial begin
    int hits;
    logic [W-1:0] rd;
    rst = 1'b0; d_in = '0; valid_in = 1'b0; err_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset.busy",  64'(busy),      64'd0);
    check("reset.valid", 64'(valid_out), 64'd0);
    check("reset.bcd",   64'(bcd_out),   64'd0);
    check("reset.blank", 64'(blank_out), 64'd0);
    check("reset.flags", 64'({sign_out, err_out}), 64'd0);
    @(negedge clk) rst = 1'b1;

    run_conv("d12345", 28'd12345, 1'b0, 0, 0);
    run_conv("neg7",   28'hFFFFFF9, 1'b0, 0, 0);
    run_conv("minneg", 28'h8000000, 1'b0, 0, 0);
    run_conv("maxpos", 28'h7FFFFFF, 1'b0, 0, 0);
    run_conv("err55",  28'd55, 1'b1, 0, 0);
    run_conv("zero",   28'd0, 1'b0, 0, 0);
    // pulses sampled at the 5th edge and at the DONE->IDLE edge are ignored
    run_conv("busy999", 28'd999, 1'b0, 4, 28);

    // Reset mid-conversion aborts with no valid_out
    @(negedge clk);
    d_in = 28'd4321; valid_in = 1'b1;
    @(posedge clk); #1;
    valid_in = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b0;
    #2;
    check("abort.busy",  64'(busy),    64'd0);
    check("abort.bcd",   64'(bcd_out), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    hits = 0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk); #1;
      if (valid_out) hits++;
    end
    check("abort.novalid", 64'(hits), 64'd0);
    check("abort.outs", 64'({sign_out, err_out, blank_out, bcd_out}), 64'd0);
    run_conv("d4321", 28'd4321, 1'b0, 0, 0);

    // Random values, mixed magnitudes, occasional error results
    for (int k = 0; k < 30; k++) begin
      rd = 28'($urandom());
      case ($urandom_range(0, 3))
        0: rd = 28'($urandom_range(0, 99));
        1: rd = -28'($urandom_range(0, 9999));
        default: ;
      endcase
      run_conv("rand", rd, ($urandom_range(0, 7) == 0), 0, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
